display_sequencer: RTL

- Sequencing controller for the stopwatch seven-segment display path.
- Generates the control inputs of the display mux block:
  - chase position `a2`
  - chase/digit select `signal`
  - the three error-display flags
  - the time/digit page select `mood`
- Inputs are debounced, clk-synchronous buttons plus the stopwatch core's `run` status.
- Owns error hold timing and the page-toggle policy, so the mux block stays purely combinational.

---
 rtl/display_ctrl_pkg.sv | 18 +
 rtl/tick_prescaler.sv | 28 ++
 rtl/display_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/display_ctrl_pkg.sv
// Shared types and constants for the stopwatch display sequencing path.
package display_ctrl_pkg;

  // Width of the chase position bus driven to the display mux.
  localparam int A2_W = 3;

  // Default number of chase positions; a2 wraps from DEF_CHASE_LEN-1 to 0.
  localparam int DEF_CHASE_LEN = 7;

  // Sequencer state: NORMAL or one of three mutually exclusive error displays.
  typedef enum logic [1:0] {
    NORMAL     = 2'd0,
    ERR_OVER   = 2'd1,
    ERR_OVER_T = 2'd2,
    ERR_CHG    = 2'd3
  } disp_state_t;

endpackage : display_ctrl_pkg

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle display tick every TICK_DIV clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] count;

  // Count 0..TICK_DIV-1 and wrap; the terminal value is the tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == CNT_LAST);

endmodule : tick_prescaler

// File: rtl/display_sequencer.sv
// Sequencing controller for the stopwatch seven-segment display mux.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// NORMAL     | no error shown; mode presses toggle the page while stopped
// ERR_OVER   | start pressed while running on the digit page
// ERR_OVER_T | start pressed while running on the time page
// ERR_CHG    | page change attempted while running
//
// Error states hold for ERR_HOLD display ticks after the last same-class
// press; presses of the other class are ignored until NORMAL is re-entered.
module display_sequencer
  import display_ctrl_pkg::*;
#(
  parameter int TICK_DIV  = 25_000_000,
  parameter int ERR_HOLD  = 4,
  parameter int CHASE_LEN = DEF_CHASE_LEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_btn,
  input  logic            mode_btn,
  input  logic            run,
  output logic [A2_W-1:0] a2,
  output logic            signal,
  output logic            mood,
  output logic            error_over_start,
  output logic            error_over_start_time,
  output logic            error_changing
);

  localparam int HOLD_W = (ERR_HOLD > 1) ? $clog2(ERR_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ERR_HOLD - 1);
  localparam logic [A2_W-1:0]   A2_LAST   = A2_W'(CHASE_LEN - 1);

  logic              tick;
  logic              start_prev;
  logic              mode_prev;
  logic              rise_start;
  logic              rise_mode;
  logic              over_evt;
  logic              chg_evt;
  logic              same_evt;
  disp_state_t       state;
  logic [HOLD_W-1:0] hold;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // Button press detection; edge registers preset to 1 so a button held
  // through reset release is not seen as a press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      start_prev <= 1'b1;
      mode_prev  <= 1'b1;
    end else begin
      start_prev <= start_btn;
      mode_prev  <= mode_btn;
    end
  end

  assign rise_start = start_btn & ~start_prev;
  assign rise_mode  = mode_btn & ~mode_prev;
  assign over_evt   = rise_start & run;
  assign chg_evt    = rise_mode & run;

  // A press of the class that caused the current error restarts its hold.
  always_comb begin
    same_evt = 1'b0;
    case (state)
      ERR_OVER, ERR_OVER_T: same_evt = over_evt;
      ERR_CHG:              same_evt = chg_evt;
      default:              same_evt = 1'b0;
    endcase
  end

  // Chase position steps on ticks while running and parks at 0 when stopped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      a2     <= '0;
      signal <= 1'b0;
    end else begin
      signal <= run;
      if (!run) begin
        a2 <= '0;
      end else if (tick) begin
        a2 <= (a2 == A2_LAST) ? '0 : a2 + A2_W'(1);
      end
    end
  end

  // Error/page FSM with its hold counter; over-start beats a simultaneous
  // mode press, and mood only ever changes from NORMAL while stopped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= NORMAL;
      hold  <= '0;
      mood  <= 1'b0;
    end else begin
      case (state)
        NORMAL: begin
          hold <= '0;
          if (over_evt) begin
            state <= mood ? ERR_OVER_T : ERR_OVER;
          end else if (chg_evt) begin
            state <= ERR_CHG;
          end else if (rise_mode) begin
            mood <= ~mood;
          end
        end
        default: begin
          if (same_evt) begin
            hold <= '0;
          end else if (tick) begin
            if (hold == HOLD_LAST) begin
              state <= NORMAL;
              hold  <= '0;
            end else begin
              hold <= hold + HOLD_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Error flags decode straight from the state register.
  assign error_over_start      = (state == ERR_OVER);
  assign error_over_start_time = (state == ERR_OVER_T);
  assign error_changing        = (state == ERR_CHG);

endmodule : display_sequencer
